k051962_tile_shifter: RTL and testbench

Pixel-side receiver for the plane address generator's tile fetch stream: one instance per tilemap plane (A, B, fix).
- Captures the 32-bit planar GFX ROM word for the current tile row, together with the tile's COL attribute and 3-bit fine scroll (Z*1H/Z*2H/Z*4H).
- Serialises the word into 4-bit pixels at the pixel rate and applies horizontal flip.
- Delays the stream by the fine-scroll amount.
- Outputs the 8-bit colour index plus an opaque flag to the priority/mixer stage.

---
 rtl/k051962_tile_shifter_if.sv | 25 ++
 rtl/k051962_tile_shifter.sv | 83 ++++++++
 tb/tb_k051962_tile_shifter.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/k051962_tile_shifter_if.sv
// Tile-row bus between the plane address generator and one pixel shifter.
// master drives the tile fetch stream and pixel strobe; slave returns the coloured pixel.
interface k051962_tile_shifter_if;
  logic        pix_ce;
  logic        tile_load;
  logic [31:0] rom_data;
  logic [7:0]  col_in;
  logic [2:0]  fine_in;
  logic        flipx_en;
  logic        flip_screen;
  logic        blank;
  logic [3:0]  pix_out;
  logic [3:0]  pal_out;
  logic        opaque;

  modport master (
    output pix_ce, tile_load, rom_data, col_in, fine_in, flipx_en, flip_screen, blank,
    input  pix_out, pal_out, opaque
  );

  modport slave (
    input  pix_ce, tile_load, rom_data, col_in, fine_in, flipx_en, flip_screen, blank,
    output pix_out, pal_out, opaque
  );
endinterface

// File: rtl/k051962_tile_shifter.sv
// Per-plane tile row serialiser: 8-entry {pix,pal} shift register, 7-stage fine-scroll delay line
// and output register; pixel 0 of a load on pix_ce edge N appears after edge N+1+fine.
module k051962_tile_shifter #(
  parameter int FLIPX_BIT = 0
) (
  input  logic                   clk_24M,
  input  logic                   nRES,
  k051962_tile_shifter_if.slave  bus
);

  logic [7:0][7:0] sr_q, sr_d;
  logic [7:1][7:0] dl_q, dl_d;
  logic [2:0]      fine_q, fine_d;
  logic [7:0]      out_q, out_d;
  logic            opaque_q, opaque_d;

  logic            rev;
  logic [3:0][7:0] plane;
  logic [7:0][7:0] load_ent;
  logic [7:0][7:0] taps;
  logic [7:0]      tap;

  assign rev = (bus.flipx_en & bus.col_in[FLIPX_BIT]) ^ bus.flip_screen;

  // Reversing each bitplane up front lets both flip cases share one unpack.
  for (genvar j = 0; j < 4; j++) begin : g_plane
    assign plane[j] = rev ? {<<{bus.rom_data[8*j +: 8]}} : bus.rom_data[8*j +: 8];
  end

  for (genvar g = 0; g < 8; g++) begin : g_unpack
    assign load_ent[g] = {plane[3][7-g], plane[2][7-g], plane[1][7-g], plane[0][7-g],
                          bus.col_in[7:4]};
  end

  // Tap 0 is the shift register head itself; tap k is delay stage k.
  assign taps = {dl_q, sr_q[0]};
  assign tap  = taps[fine_q];

  always_comb begin
    sr_d     = sr_q;
    dl_d     = dl_q;
    fine_d   = fine_q;
    out_d    = out_q;
    opaque_d = opaque_q;
    if (bus.pix_ce) begin
      if (bus.tile_load) begin
        sr_d   = load_ent;
        fine_d = bus.fine_in;
      end else begin
        sr_d = {8'h00, sr_q[7:1]};
      end
      dl_d = {dl_q[6:1], sr_q[0]};
      if (bus.blank) begin
        out_d    = 8'h00;
        opaque_d = 1'b0;
      end else begin
        out_d    = tap;
        opaque_d = |tap[7:4];
      end
    end
  end

  always_ff @(posedge clk_24M or negedge nRES) begin
    if (!nRES) begin
      sr_q     <= '0;
      dl_q     <= '0;
      fine_q   <= 3'd0;
      out_q    <= 8'h00;
      opaque_q <= 1'b0;
    end else begin
      sr_q     <= sr_d;
      dl_q     <= dl_d;
      fine_q   <= fine_d;
      out_q    <= out_d;
      opaque_q <= opaque_d;
    end
  end

  assign bus.pix_out = out_q[7:4];
  assign bus.pal_out = out_q[3:0];
  assign bus.opaque  = opaque_q;

endmodule

// File: tb/tb_k051962_tile_shifter.sv
// Randomised scoreboard bench for k051962_tile_shifter with a timeline reference model
// plus directed checks of the serialise, flip, fine-scroll, drain, blank and reset cases.
module tb_k051962_tile_shifter;
  localparam int FLIPX_BIT = 0;

  logic clk  = 1'b0;
  logic nres = 1'b0;
  always #5 clk = ~clk;

  k051962_tile_shifter_if ifc();

  k051962_tile_shifter #(.FLIPX_BIT(FLIPX_BIT)) dut (
    .clk_24M (clk),
    .nRES    (nres),
    .bus     (ifc)
  );

  typedef struct packed {
    logic [3:0] pix;
    logic [3:0] pal;
    logic       opq;
  } exp_t;

  int   chk_cnt  = 0;
  int   pass_cnt = 0;
  exp_t exp_q[$];
  exp_t last_exp;

  // Reference model: the head of the shift register at pix_ce edge t is pixel (t-1-L)
  // of the most recent load L (or transparent once 8 pixels have gone by); the output
  // after edge t is the head as it was fine edges earlier.
  logic [7:0] head_hist[$];
  logic [7:0] tile_m[8];
  int         last_ld;
  int         ce_t;
  int         fine_m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    chk_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
  endtask

  task automatic model_reset();
    head_hist.delete();
    head_hist.push_back(8'h00);
    last_ld  = -100;
    ce_t     = 0;
    fine_m   = 0;
    exp_q.delete();
    last_exp = '0;
  endtask

  task automatic model_step();
    int         s;
    int         age;
    logic [7:0] h;
    logic [7:0] pl [4];
    logic [2:0] b;
    logic       rv;
    exp_t       e;
    s = ce_t - fine_m;
    h = (s < 0) ? 8'h00 : head_hist[s];
    if (ifc.blank) e = '0;
    else           e = '{pix: h[7:4], pal: h[3:0], opq: (h[7:4] != 4'h0)};
    exp_q.push_back(e);
    if (ifc.tile_load) begin
      rv = (ifc.flipx_en & ifc.col_in[FLIPX_BIT]) ^ ifc.flip_screen;
      for (int p = 0; p < 4; p++) pl[p] = ifc.rom_data[8*p +: 8];
      for (int i = 0; i < 8; i++) begin
        b = rv ? 3'(i) : 3'(7 - i);
        tile_m[i] = {pl[3][b], pl[2][b], pl[1][b], pl[0][b], ifc.col_in[7:4]};
      end
      last_ld = ce_t;
      fine_m  = int'(ifc.fine_in);
    end
    age = ce_t - last_ld;
    ce_t++;
    head_hist.push_back((age < 8) ? tile_m[age] : 8'h00);
  endtask

  task automatic randomize_dont_care();
    ifc.tile_load   = 1'($urandom);
    ifc.rom_data    = $urandom;
    ifc.col_in      = 8'($urandom);
    ifc.fine_in     = 3'($urandom);
    ifc.flipx_en    = 1'($urandom);
    ifc.flip_screen = 1'($urandom);
    ifc.blank       = 1'($urandom);
  endtask

  task automatic pix_tick(input bit ld, input bit blk);
    @(negedge clk);
    ifc.pix_ce    = 1'b1;
    ifc.tile_load = ld;
    ifc.blank     = blk;
    model_step();
    @(negedge clk);
    ifc.pix_ce = 1'b0;
    randomize_dont_care();
    @(negedge clk);
    randomize_dont_care();
  endtask

  task automatic set_tile(input logic [31:0] rom, input logic [7:0] col, input logic [2:0] fine,
                          input bit fx, input bit fs);
    ifc.rom_data    = rom;
    ifc.col_in      = col;
    ifc.fine_in     = fine;
    ifc.flipx_en    = fx;
    ifc.flip_screen = fs;
  endtask

  task automatic do_reset();
    @(negedge clk);
    ifc.pix_ce = 1'b0;
    nres = 1'b0;
    #1;
    check("rst_pix", 32'(ifc.pix_out), 32'h0);
    check("rst_pal", 32'(ifc.pal_out), 32'h0);
    check("rst_opq", 32'(ifc.opaque), 32'h0);
    model_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      ifc.pix_ce    = 1'b1;
      ifc.tile_load = 1'b1;
      @(negedge clk);
      ifc.pix_ce    = 1'b0;
    end
    @(negedge clk);
    nres = 1'b1;
  endtask

  bit   ce_s, rs_s;
  exp_t e_m;
  initial begin
    forever begin
      @(posedge clk);
      ce_s = ifc.pix_ce;
      rs_s = nres;
      #2;
      if (!rs_s || !nres) begin
        check("rst_hold_pix", 32'(ifc.pix_out), 32'h0);
        check("rst_hold_opq", 32'(ifc.opaque), 32'h0);
      end else if (ce_s) begin
        if (exp_q.size() == 0) begin
          check("sb_underflow", 32'(exp_q.size()), 32'd1);
        end else begin
          e_m = exp_q.pop_front();
          check("sb_pix", 32'(ifc.pix_out), 32'(e_m.pix));
          check("sb_pal", 32'(ifc.pal_out), 32'(e_m.pal));
          check("sb_opq", 32'(ifc.opaque), 32'(e_m.opq));
          last_exp = e_m;
        end
      end else begin
        check("hold_pix", 32'(ifc.pix_out), 32'(last_exp.pix));
        check("hold_pal", 32'(ifc.pal_out), 32'(last_exp.pal));
        check("hold_opq", 32'(ifc.opaque), 32'(last_exp.opq));
      end
    end
  end

  initial begin
    ifc.pix_ce = 1'b0;
    ifc.tile_load = 1'b0;
    ifc.blank = 1'b0;
    set_tile(32'h0, 8'h0, 3'd0, 1'b0, 1'b0);
    model_reset();

    // Reset with pix_ce toggling, then an idle stretch with no loads.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); ifc.pix_ce = 1'b1; ifc.tile_load = 1'b1;
      @(negedge clk); ifc.pix_ce = 1'b0;
    end
    check("init_pix", 32'(ifc.pix_out), 32'h0);
    check("init_opq", 32'(ifc.opaque), 32'h0);
    @(negedge clk); nres = 1'b1;
    for (int i = 0; i < 8; i++) begin
      pix_tick(1'b0, 1'b0);
      check("idle_pix", 32'(ifc.pix_out), 32'h0);
    end

    // Basic serialise.
    set_tile(32'h0F3355FF, 8'hA0, 3'd0, 1'b0, 1'b0);
    pix_tick(1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      pix_tick(1'b0, 1'b0);
      check("basic_pix", 32'(ifc.pix_out), 32'(2*i + 1));
      check("basic_pal", 32'(ifc.pal_out), 32'hA);
      check("basic_opq", 32'(ifc.opaque), 32'h1);
    end

    // Per-tile X-flip, then cancelled by screen flip.
    set_tile(32'h0F3355FF, 8'hA1, 3'd0, 1'b1, 1'b0);
    pix_tick(1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      pix_tick(1'b0, 1'b0);
      check("flipx_pix", 32'(ifc.pix_out), 32'(15 - 2*i));
    end
    set_tile(32'h0F3355FF, 8'hA1, 3'd0, 1'b1, 1'b1);
    pix_tick(1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      pix_tick(1'b0, 1'b0);
      check("flipxs_pix", 32'(ifc.pix_out), 32'(2*i + 1));
    end

    // Fine scroll 5: T0 at edge N, T1 at edge N+8.
    set_tile(32'h0F3355FF, 8'hA0, 3'd5, 1'b0, 1'b0);
    pix_tick(1'b1, 1'b0);
    for (int j = 1; j <= 20; j++) begin
      if (j == 8) begin
        set_tile(32'h0000FF00, 8'h50, 3'd5, 1'b0, 1'b0);
        pix_tick(1'b1, 1'b0);
      end else begin
        pix_tick(1'b0, 1'b0);
      end
      if (j == 6)  check("fine_t0p0", 32'(ifc.pix_out), 32'h1);
      if (j == 13) check("fine_t0p7", 32'(ifc.pix_out), 32'hF);
      if (j == 14) check("fine_t1p0", 32'(ifc.pix_out), 32'h2);
      if (j == 14) check("fine_t1pal", 32'(ifc.pal_out), 32'h5);
      if (j == 21 - 1) check("fine_drained", 32'(ifc.pix_out), 32'h2);
    end

    // Drain to transparent.
    set_tile(32'h00000001, 8'hC0, 3'd0, 1'b0, 1'b0);
    pix_tick(1'b1, 1'b0);
    for (int i = 0; i < 12; i++) begin
      pix_tick(1'b0, 1'b0);
      check("drain_pix", 32'(ifc.pix_out), (i == 7) ? 32'h1 : 32'h0);
      check("drain_opq", 32'(ifc.opaque), (i == 7) ? 32'h1 : 32'h0);
    end

    // Blank for three pixels mid-tile.
    set_tile(32'h0F3355FF, 8'hA0, 3'd0, 1'b0, 1'b0);
    pix_tick(1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      pix_tick(1'b0, (i >= 2 && i <= 4));
      check("blank_pix", 32'(ifc.pix_out), (i >= 2 && i <= 4) ? 32'h0 : 32'(2*i + 1));
    end

    // Load together with blank: output forced 0, tile still loaded.
    set_tile(32'h0F3355FF, 8'hA0, 3'd0, 1'b0, 1'b0);
    pix_tick(1'b1, 1'b1);
    check("ldblank_pix", 32'(ifc.pix_out), 32'h0);
    pix_tick(1'b0, 1'b0);
    check("ldblank_p0", 32'(ifc.pix_out), 32'h1);

    // Reset mid-tile.
    set_tile(32'h0F3355FF, 8'hA0, 3'd0, 1'b0, 1'b0);
    pix_tick(1'b1, 1'b0);
    repeat (3) pix_tick(1'b0, 1'b0);
    do_reset();
    for (int i = 0; i < 8; i++) begin
      pix_tick(1'b0, 1'b0);
      check("postrst_pix", 32'(ifc.pix_out), 32'h0);
    end

    // Randomised traffic: irregular and periodic loads, blanking, occasional reset.
    for (int n = 0; n < 600; n++) begin
      bit ld;
      if (n < 300) ld = ($urandom_range(0, 9) == 0);
      else         ld = ((n % 8) == 0);
      if ($urandom_range(0, 199) == 0) do_reset();
      pix_tick(ld, ($urandom_range(0, 9) == 0));
    end

    repeat (4) @(negedge clk);
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
